// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and the single-transfer master FSM state type.
// Contents:
//   htrans_e      - HTRANS transfer type encodings
//   HRESP_*       - HRESP response encodings
//   HSIZE_WORD    - 32-bit transfer size
//   HBURST_SINGLE - single (non-burst) transfer
//   HPROT_DATA    - privileged data access, non-cacheable, non-bufferable
//   mst_state_e   - master FSM states
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_RSP  = 2'b11
    } mst_state_e;

endpackage

// File: rtl/ahb_sws_master.sv
// ----------------------------------------------------------------------------
// ahb_sws_master
// Single-word, single-outstanding AHB-Lite master. Turns one valid/ready
// command into one NONSEQ SINGLE word transfer and returns a valid/ready
// response carrying read data and error/timeout status.
// Ports:
//   clk_i, rst_i                 - clock, asynchronous active-high reset
//   req_valid_i/req_ready_o      - command handshake (ready only when idle)
//   req_write_i/addr_i/wdata_i   - command fields
//   rsp_valid_o/rsp_ready_i      - response handshake
//   rsp_rdata_o/err_o/timeout_o  - response fields
//   h*_o / h*_i                  - AHB-Lite master bus
//   busy_o                       - a command is in flight
// ----------------------------------------------------------------------------
module ahb_sws_master
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [DATA_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [3:0]            hprot_o,
    output logic                  hmastlock_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mst_state_e            state_q, state_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (req_addr_i[1:0] == 2'b00) begin
                        addr_d  = req_addr_i;
                        write_d = req_write_i;
                        wdata_d = req_wdata_i;
                        state_d = S_ADDR;
                    end else begin
                        // Unaligned word access never reaches the bus.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = S_RSP;
                    end
                end
            end
            S_ADDR: begin
                if (hready_i) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // The first ERROR cycle arrives with hready low and is just
                // another wait cycle; the transfer ends on the hready edge.
                if (hready_i) begin
                    err_d   = (hresp_i != HRESP_OKAY);
                    tmo_d   = 1'b0;
                    rdata_d = (!write_q && hresp_i == HRESP_OKAY) ? hrdata_i : '0;
                    state_d = S_RSP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload registers need no reset: every output that exposes them is
    // gated by the state that makes them meaningful.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rsp_valid_o   = (state_q == S_RSP);
    assign rsp_err_o     = (state_q == S_RSP) && err_q;
    assign rsp_timeout_o = (state_q == S_RSP) && tmo_q;
    assign rsp_rdata_o   = (state_q == S_RSP) ? rdata_q : '0;

    assign htrans_o    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_o     = (state_q == S_ADDR) ? addr_q : '0;
    assign hwrite_o    = (state_q == S_ADDR) && write_q;
    assign hwdata_o    = (state_q == S_DATA && write_q) ? wdata_q : '0;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HPROT_DATA;
    assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_ahb_sws_master.sv
// ----------------------------------------------------------------------------
// tb_ahb_sws_master
// Directed bench for ahb_sws_master (TIMEOUT_CYCLES=4). Inputs change 1 time
// unit after each rising edge; "cycle N" is the cycle in which the command
// handshake is high, so the accepting edge closes cycle N.
// ----------------------------------------------------------------------------
module tb_ahb_sws_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic        hwrite, hmastlock, hready, busy;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int errors = 0;
    int checks = 0;

    ahb_sws_master #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite), .hsize_o(hsize),
        .hburst_o(hburst), .hprot_o(hprot), .hmastlock_o(hmastlock),
        .hwdata_o(hwdata), .hready_i(hready), .hresp_i(hresp), .hrdata_i(hrdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'hffff_fffc;
        req_wdata = 32'h5555_5555;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; hready = 1'b1; hresp = 2'b00; hrdata = '0;

        // Reset state
        #3;
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // Zero-wait write
        issue(1'b1, 32'h8010_00ac, 32'hcafe_cafe);
        chk("wr_ready_N", 32'(req_ready), 32'h1);
        tick(); drop_req();
        chk("wr_htrans_N1", 32'(htrans), 32'h2);
        chk("wr_haddr_N1", haddr, 32'h8010_00ac);
        chk("wr_hwrite_N1", 32'(hwrite), 32'h1);
        chk("wr_hsize", 32'(hsize), 32'h2);
        chk("wr_hburst", 32'(hburst), 32'h0);
        chk("wr_hprot", 32'(hprot), 32'h3);
        chk("wr_hmastlock", 32'(hmastlock), 32'h0);
        chk("wr_hwdata_N1", hwdata, 32'h0);
        tick();
        chk("wr_htrans_N2", 32'(htrans), 32'h0);
        chk("wr_hwdata_N2", hwdata, 32'hcafe_cafe);
        chk("wr_rsp_valid_N2", 32'(rsp_valid), 32'h0);
        tick();
        chk("wr_rsp_valid_N3", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_err_N3", 32'(rsp_err), 32'h0);
        chk("wr_rsp_rdata_N3", rsp_rdata, 32'h0);
        chk("wr_req_ready_N3", 32'(req_ready), 32'h0);
        chk("wr_hwdata_N3", hwdata, 32'h0);
        tick();
        chk("wr_rsp_hold", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        chk("wr_rsp_done", 32'(rsp_valid), 32'h0);
        chk("wr_ready_again", 32'(req_ready), 32'h1);

        // Read with two wait cycles
        issue(1'b0, 32'h8010_0004, 32'h0);
        tick(); drop_req();
        chk("rd_htrans_N1", 32'(htrans), 32'h2);
        chk("rd_hwrite_N1", 32'(hwrite), 32'h0);
        tick(); hready = 1'b0;
        chk("rd_hwdata_N2", hwdata, 32'h0);
        tick();
        chk("rd_busy_N3", 32'(busy), 32'h1);
        tick(); hready = 1'b1; hrdata = 32'h1234_5678;
        chk("rd_rsp_valid_N4", 32'(rsp_valid), 32'h0);
        tick(); hrdata = 32'h0;
        chk("rd_rsp_valid_N5", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata_N5", rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err_N5", 32'(rsp_err), 32'h0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;

        // Two-cycle ERROR response on a write
        issue(1'b1, 32'h8010_0010, 32'h1111_2222);
        tick(); drop_req();
        tick(); hready = 1'b0; hresp = 2'b01;
        chk("er_hwdata_N2", hwdata, 32'h1111_2222);
        tick(); hready = 1'b1; hresp = 2'b01;
        chk("er_rsp_valid_N3", 32'(rsp_valid), 32'h0);
        chk("er_hwdata_N3", hwdata, 32'h1111_2222);
        tick(); hresp = 2'b00;
        chk("er_rsp_valid_N4", 32'(rsp_valid), 32'h1);
        chk("er_rsp_err_N4", 32'(rsp_err), 32'h1);
        chk("er_rsp_timeout_N4", 32'(rsp_timeout), 32'h0);
        chk("er_rsp_rdata_N4", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;

        // Unaligned address
        issue(1'b0, 32'h8010_0002, 32'h0);
        tick(); drop_req();
        chk("ua_htrans_N1", 32'(htrans), 32'h0);
        chk("ua_rsp_valid_N1", 32'(rsp_valid), 32'h1);
        chk("ua_rsp_err_N1", 32'(rsp_err), 32'h1);
        chk("ua_rsp_timeout_N1", 32'(rsp_timeout), 32'h0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;

        // Timeout after 4 wait cycles
        issue(1'b0, 32'h8010_0008, 32'h0);
        tick(); drop_req();
        tick(); hready = 1'b0; hrdata = 32'hdead_beef;
        tick(); tick(); tick();
        chk("to_rsp_valid_N5", 32'(rsp_valid), 32'h0);
        tick();
        chk("to_rsp_valid_N6", 32'(rsp_valid), 32'h1);
        chk("to_rsp_err_N6", 32'(rsp_err), 32'h1);
        chk("to_rsp_timeout_N6", 32'(rsp_timeout), 32'h1);
        chk("to_rsp_rdata_N6", rsp_rdata, 32'h0);
        hready = 1'b1; hrdata = 32'h0; rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        chk("to_idle", 32'(busy), 32'h0);

        // Reset during DATA, then a clean write
        issue(1'b1, 32'h8010_0020, 32'ha5a5_a5a5);
        tick(); drop_req();
        tick(); hready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mr_htrans", 32'(htrans), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_hwdata", hwdata, 32'h0);
        rst = 1'b0; hready = 1'b1;
        tick();
        chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h1);
        issue(1'b1, 32'h8010_0030, 32'h0bad_f00d);
        tick(); drop_req();
        chk("mr_htrans_N1", 32'(htrans), 32'h2);
        chk("mr_haddr_N1", haddr, 32'h8010_0030);
        tick();
        chk("mr_hwdata_N2", hwdata, 32'h0bad_f00d);
        tick();
        chk("mr_rsp_valid_N3", 32'(rsp_valid), 32'h1);
        chk("mr_rsp_err_N3", 32'(rsp_err), 32'h0);
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        chk("mr_final_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
